// File: rtl/s64x7_bus_pkg.sv
// Shared widths, reset vector, responder state encoding and lane helpers
// for the S64X7 bus responder slice.
package s64x7_bus_pkg;

  localparam int unsigned ADR_W  = 61;  // doubleword address [63:3]
  localparam int unsigned DAT_W  = 64;
  localparam int unsigned SEL_W  = 8;   // one enable per byte lane
  localparam int unsigned WAIT_W = 4;   // wait counter width
  localparam int unsigned WAIT_MAX = (1 << WAIT_W) - 1;

  localparam logic [63:0] RESET_VECTOR = 64'hE000_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  // Expand byte-lane enables into a bit mask over the data word.
  function automatic logic [DAT_W-1:0] lane_mask(input logic [SEL_W-1:0] sel);
    logic [DAT_W-1:0] m;
    m = '0;
    for (int b = 0; b < SEL_W; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/s64x7_bus_responder_if.sv
// S64X7 processor-bus signal bundle. Signal names follow the slave's view.
interface s64x7_bus_responder_if;
  import s64x7_bus_pkg::*;

  logic [ADR_W-1:0] adr_i;
  logic             cyc_i;
  logic             stb_i;
  logic [SEL_W-1:0] sel_i;
  logic             we_i;
  logic             vpa_i;
  logic [DAT_W-1:0] dat_i;
  logic             ack_o;
  logic [DAT_W-1:0] dat_o;

  modport master (
    output adr_i, cyc_i, stb_i, sel_i, we_i, vpa_i, dat_i,
    input  ack_o, dat_o
  );

  modport slave (
    input  adr_i, cyc_i, stb_i, sel_i, we_i, vpa_i, dat_i,
    output ack_o, dat_o
  );

endinterface

// File: rtl/s64x7_bytelane_ram.sv
// 2^AW x 64 storage with per-byte write enables and a single port.
// Writes are synchronous; the read port is combinational so the responder
// can capture the word into its own output register on the same edge.
// The array is deliberately not reset.
module s64x7_bytelane_ram
  import s64x7_bus_pkg::*;
#(
  parameter int unsigned AW = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [SEL_W-1:0] be_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [DAT_W-1:0] wdata_i,
  output logic [DAT_W-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AW;

  logic [DAT_W-1:0] mem_q [Depth];
  logic [DAT_W-1:0] wmask;

  assign wmask = lane_mask(be_i);

  // Merge enabled lanes into the addressed word; other lanes keep their value.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~wmask) | (wdata_i & wmask);
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/s64x7_bus_responder.sv
// Wait-state-programmable 64-bit memory slave on the S64X7 bus.
// A request is latched in IDLE, optionally counted down in WAIT, and
// acknowledged for exactly one cycle in ACK. Storage access (write commit
// and read capture) happens on the edge that enters ACK. Addresses outside
// the 2^AW-word window are still acked; reads return zero, writes vanish.
module s64x7_bus_responder
  import s64x7_bus_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = RESET_VECTOR,
  parameter int unsigned AW         = 6,
  parameter int unsigned DATA_WAIT  = 0,
  parameter int unsigned FETCH_WAIT = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  s64x7_bus_responder_if.slave  bus
);

  localparam int unsigned TAG_LSB = AW + 3;  // lowest byte-address bit above window
  localparam int unsigned TAG_W   = ADR_W - AW;

  localparam logic [TAG_W-1:0]  BASE_TAG     = BASE_ADDR[63:TAG_LSB];
  localparam logic [WAIT_W-1:0] DATA_WAIT_C  = WAIT_W'(DATA_WAIT);
  localparam logic [WAIT_W-1:0] FETCH_WAIT_C = WAIT_W'(FETCH_WAIT);

  // Build-time guards on parameter ranges.
  if (DATA_WAIT > WAIT_MAX || FETCH_WAIT > WAIT_MAX) begin : g_bad_wait
    $error("s64x7_bus_responder: wait parameter exceeds 15");
  end
  if (AW < 1 || AW > 58) begin : g_bad_aw
    $error("s64x7_bus_responder: AW out of range");
  end
  if (BASE_ADDR[TAG_LSB-1:0] != '0) begin : g_bad_base
    $error("s64x7_bus_responder: BASE_ADDR not aligned to window");
  end

  state_e            state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [AW-1:0]     idx_q;
  logic [SEL_W-1:0]  sel_q;
  logic              we_q;
  logic              hit_q;
  logic [DAT_W-1:0]  wdat_q;
  logic              ack_q;
  logic [DAT_W-1:0]  rdat_q;

  logic              req;
  logic              hit_live;
  logic [WAIT_W-1:0] wait_ld;

  // Access selected for the edge entering ACK.
  logic              commit;
  logic              acc_we;
  logic              acc_hit;
  logic [SEL_W-1:0]  acc_sel;
  logic [AW-1:0]     acc_idx;
  logic [DAT_W-1:0]  acc_dat;
  logic [DAT_W-1:0]  ram_rdata;

  assign req      = bus.cyc_i & bus.stb_i;
  assign hit_live = (bus.adr_i[ADR_W-1:AW] == BASE_TAG);
  assign wait_ld  = bus.vpa_i ? FETCH_WAIT_C : DATA_WAIT_C;

  // Pick live bus fields for a zero-wait IDLE request, latched ones otherwise.
  always_comb begin
    commit  = 1'b0;
    acc_we  = we_q;
    acc_hit = hit_q;
    acc_sel = sel_q;
    acc_idx = idx_q;
    acc_dat = wdat_q;
    unique case (state_q)
      IDLE: begin
        acc_we  = bus.we_i;
        acc_hit = hit_live;
        acc_sel = bus.sel_i;
        acc_idx = bus.adr_i[AW-1:0];
        acc_dat = bus.dat_i;
        commit  = req && (wait_ld == '0);
      end
      WAIT: begin
        commit = req && (cnt_q == WAIT_W'(1));
      end
      default: begin
        commit = 1'b0;
      end
    endcase
  end

  s64x7_bytelane_ram #(
    .AW (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (commit & acc_we & acc_hit),
    .be_i    (acc_sel),
    .addr_i  (acc_idx),
    .wdata_i (acc_dat),
    .rdata_o (ram_rdata)
  );

  // Responder FSM with registered ack and read data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      // Reads update dat_o only on the ACK-entry edge; writes leave it alone.
      if (commit && !acc_we) begin
        rdat_q <= acc_hit ? ram_rdata : '0;
      end
      unique case (state_q)
        IDLE: begin
          if (req) begin
            idx_q  <= bus.adr_i[AW-1:0];
            sel_q  <= bus.sel_i;
            we_q   <= bus.we_i;
            hit_q  <= hit_live;
            wdat_q <= bus.dat_i;
            cnt_q  <= wait_ld;
            if (commit) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            // Master abandoned the cycle: no commit, no ack.
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - WAIT_W'(1);
            if (commit) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
            end
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.dat_o = rdat_q;

endmodule

// File: tb/tb_s64x7_bus_responder.sv
// Scoreboard bench for s64x7_bus_responder. Three instances cover the
// zero-wait, (DATA_WAIT=3, FETCH_WAIT=1) and DATA_WAIT=5 builds. Stimulus
// pushes the expected ack cycle and read data; a negedge monitor pops and
// compares whenever an instance raises ack_o.
module tb_s64x7_bus_responder;
  import s64x7_bus_pkg::*;

  localparam logic [63:0] B = 64'hE000_0000_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [ADR_W-1:0] adr_r [3];
  logic [2:0]       cyc_r, stb_r, we_r, vpa_r;
  logic [SEL_W-1:0] sel_r [3];
  logic [DAT_W-1:0] dat_r [3];
  logic [2:0]       ack_w;
  logic [DAT_W-1:0] rd_w [3];

  int          checks   = 0;
  int          failures = 0;
  int unsigned cnt      = 0;

  always @(posedge clk) cnt <= cnt + 1;

  s64x7_bus_responder_if bif0 ();
  s64x7_bus_responder_if bif1 ();
  s64x7_bus_responder_if bif2 ();

  assign bif0.adr_i = adr_r[0];  assign bif1.adr_i = adr_r[1];  assign bif2.adr_i = adr_r[2];
  assign bif0.cyc_i = cyc_r[0];  assign bif1.cyc_i = cyc_r[1];  assign bif2.cyc_i = cyc_r[2];
  assign bif0.stb_i = stb_r[0];  assign bif1.stb_i = stb_r[1];  assign bif2.stb_i = stb_r[2];
  assign bif0.sel_i = sel_r[0];  assign bif1.sel_i = sel_r[1];  assign bif2.sel_i = sel_r[2];
  assign bif0.we_i  = we_r[0];   assign bif1.we_i  = we_r[1];   assign bif2.we_i  = we_r[2];
  assign bif0.vpa_i = vpa_r[0];  assign bif1.vpa_i = vpa_r[1];  assign bif2.vpa_i = vpa_r[2];
  assign bif0.dat_i = dat_r[0];  assign bif1.dat_i = dat_r[1];  assign bif2.dat_i = dat_r[2];
  assign ack_w[0] = bif0.ack_o;  assign ack_w[1] = bif1.ack_o;  assign ack_w[2] = bif2.ack_o;
  assign rd_w[0]  = bif0.dat_o;  assign rd_w[1]  = bif1.dat_o;  assign rd_w[2]  = bif2.dat_o;

  s64x7_bus_responder u_dut0 (
    .clk_i   (clk),
    .reset_i (rst[0]),
    .bus     (bif0)
  );

  s64x7_bus_responder #(
    .DATA_WAIT  (3),
    .FETCH_WAIT (1)
  ) u_dut1 (
    .clk_i   (clk),
    .reset_i (rst[1]),
    .bus     (bif1)
  );

  s64x7_bus_responder #(
    .DATA_WAIT (5)
  ) u_dut2 (
    .clk_i   (clk),
    .reset_i (rst[2]),
    .bus     (bif2)
  );

  typedef struct {
    int unsigned cyc;
    logic [63:0] data;
    bit          chk;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qsize(input int d, output int n);
    case (d)
      0: n = q0.size();
      1: n = q1.size();
      default: n = q2.size();
    endcase
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   n;
    if (ack_w[d]) begin
      qsize(d, n);
      checks++;
      if (n == 0) begin
        failures++;
        $display("FAIL unexpected_ack dut%0d: ack at cycle %0d, none required", d, cnt);
      end else begin
        case (d)
          0: e = q0.pop_front();
          1: e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        if (cnt != e.cyc) begin
          failures++;
          $display("FAIL %s_latency dut%0d: ack at cycle %0d, required cycle %0d",
                   e.name, d, cnt, e.cyc);
        end
        if (e.chk) begin
          checks++;
          if (rd_w[d] !== e.data) begin
            failures++;
            $display("FAIL %s_data dut%0d: got %h, required %h", e.name, d, rd_w[d], e.data);
          end
        end
      end
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) mon(d);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic wait_ack(input int d, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack_w[d]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout dut%0d: no ack within 40 cycles, required one", nm, d);
    end
  endtask

  task automatic drive(input int d, input bit we, input logic [63:0] badr,
                       input logic [7:0] sel, input logic [63:0] dat, input bit vpa);
    adr_r[d] = badr[63:3];
    sel_r[d] = sel;
    dat_r[d] = dat;
    we_r[d]  = we;
    vpa_r[d] = vpa;
    cyc_r[d] = 1'b1;
    stb_r[d] = 1'b1;
  endtask

  task automatic release_bus(input int d);
    cyc_r[d] = 1'b0;
    stb_r[d] = 1'b0;
  endtask

  // One complete transfer; expected ack lands wait cycles after the sampling edge.
  task automatic xfer(input int d, input bit we, input logic [63:0] badr, input logic [7:0] sel,
                      input logic [63:0] dat, input bit vpa, input logic [63:0] exp_d,
                      input int unsigned w, input string nm);
    exp_t e;
    @(posedge clk); #1;
    drive(d, we, badr, sel, dat, vpa);
    e.cyc  = cnt + 1 + w;
    e.data = exp_d;
    e.chk  = !we;
    e.name = nm;
    push(d, e);
    wait_ack(d, nm);
    @(posedge clk); #1;
    release_bus(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    rst   = 3'b111;
    cyc_r = '0; stb_r = '0; we_r = '0; vpa_r = '0;
    for (int d = 0; d < 3; d++) begin
      adr_r[d] = '0; sel_r[d] = '0; dat_r[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 3'b000;

    // ---- dut0: zero-wait build ----
    xfer(0, 1, B, 8'hFF, 64'h3340_0003_1111_1110, 0, '0, 0, "preload");
    @(posedge clk); #1 rst[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_ack", {63'd0, ack_w[0]}, 64'd0);
      chk("reset_dat", rd_w[0], 64'd0);
    end
    @(posedge clk); #1 rst[0] = 1'b0;
    xfer(0, 0, B, 8'hFF, '0, 1, 64'h3340_0003_1111_1110, 0, "vector_fetch");

    xfer(0, 1, B + 64'h8, 8'hFF, 64'h0, 0, '0, 0, "clr1");
    xfer(0, 1, B + 64'h8, 8'b0000_0010, 64'h4141_4141_4141_4141, 0, '0, 0, "byte_wr");
    xfer(0, 0, B + 64'h8, 8'h01, '0, 0, 64'h0000_0000_0000_4100, 0, "byte_rd");

    xfer(0, 1, B + 64'h10, 8'hFF, 64'h0, 0, '0, 0, "clr2");
    xfer(0, 1, B + 64'h10, 8'b0000_0011, 64'h0041_0041_0041_0041, 0, '0, 0, "half_wr");
    xfer(0, 1, B + 64'h10, 8'b1111_0000, 64'h0000_0041_0000_0041, 0, '0, 0, "word_wr");
    xfer(0, 0, B + 64'h10, 8'h00, '0, 0, 64'h0000_0041_0000_0041, 0, "lanes_rd");

    // Miss: window index of $1111_1110 is word 34; preload that word first.
    xfer(0, 1, B + 64'd272, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, '0, 0, "alias_pre");
    xfer(0, 0, 64'h1111_1110, 8'hFF, '0, 0, 64'h0, 0, "miss_rd");
    xfer(0, 1, 64'h1111_1110, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, '0, 0, "miss_wr");
    xfer(0, 0, B + 64'd272, 8'hFF, '0, 0, 64'h0123_4567_89AB_CDEF, 0, "alias_rd");

    // Back-to-back reads with req held: acks two cycles apart.
    @(posedge clk); #1;
    drive(0, 0, B + 64'h8, 8'hFF, '0, 0);
    e.data = 64'h0000_0000_0000_4100; e.chk = 1'b1;
    e.cyc = cnt + 1; e.name = "b2b_first";  push(0, e);
    e.cyc = cnt + 3; e.name = "b2b_second"; push(0, e);
    repeat (3) @(posedge clk);
    #1 release_bus(0);

    // Reset while ack_o is high clears it (and dat_o) without waiting for an edge.
    @(posedge clk); #1;
    drive(0, 0, B, 8'hFF, '0, 0);
    e.cyc = cnt + 1; e.data = 64'h3340_0003_1111_1110; e.name = "pre_reset_rd"; push(0, e);
    wait_ack(0, "pre_reset_rd");
    #1 rst[0] = 1'b1;
    #1;
    chk("async_ack_clear", {63'd0, ack_w[0]}, 64'd0);
    chk("async_dat_clear", rd_w[0], 64'd0);
    release_bus(0);
    @(posedge clk); #1 rst[0] = 1'b0;

    // ---- dut1: DATA_WAIT=3, FETCH_WAIT=1 ----
    xfer(1, 1, B, 8'hFF, 64'hAAAA_5555_0000_FFFF, 0, '0, 3, "w3_wr");
    xfer(1, 0, B, 8'hFF, '0, 0, 64'hAAAA_5555_0000_FFFF, 3, "w3_data_rd");
    xfer(1, 0, B, 8'hFF, '0, 1, 64'hAAAA_5555_0000_FFFF, 1, "w1_fetch_rd");
    // Abort a write after two WAIT edges; nothing is pushed, so any ack is flagged.
    @(posedge clk); #1;
    drive(1, 1, B, 8'hFF, 64'h0000_0000_0000_1234, 0);
    repeat (3) @(posedge clk);
    #1 release_bus(1);
    repeat (6) @(posedge clk);
    xfer(1, 0, B, 8'hFF, '0, 0, 64'hAAAA_5555_0000_FFFF, 3, "post_abort_rd");

    // ---- dut2: DATA_WAIT=5, reset during WAIT ----
    xfer(2, 1, B + 64'h18, 8'hFF, 64'hCAFE_F00D_DEAD_BEEF, 0, '0, 5, "w5_wr");
    @(posedge clk); #1;
    drive(2, 1, B + 64'h18, 8'hFF, 64'h0, 0);
    repeat (3) @(posedge clk);
    #1 rst[2] = 1'b1;
    #1;
    chk("wait_reset_ack", {63'd0, ack_w[2]}, 64'd0);
    release_bus(2);
    repeat (2) @(posedge clk);
    #1 rst[2] = 1'b0;
    xfer(2, 0, B + 64'h18, 8'hFF, '0, 0, 64'hCAFE_F00D_DEAD_BEEF, 5, "post_reset_rd");

    repeat (5) @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      qsize(d, n);
      checks++;
      if (n != 0) begin
        failures++;
        $display("FAIL missing_acks dut%0d: %0d expected acks outstanding, required 0", d, n);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
